pll_bringup_seq: RTL and testbench

//  Parametrised PLL bring-up and domain-reset sequencer for N PLLs (HyperRAM, HDMI, DSI, ...).
//  Per PLL: drives the PLL reset, waits for a stable lock, then releases that clock domain's reset.

---
 rtl/pll_bringup_seq.sv | 165 ++++++++++++++++
 tb/tb_pll_bringup_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_bringup_seq.sv
// PLL bring-up and clock-domain reset sequencer: one FSM per PLL drives the PLL reset,
// waits for a stable synchronised lock, then releases that domain's reset; handles retries and lock loss.

module pll_bringup_ch #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRY    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic lock_a,
    input  logic pred_ok,
    output logic pll_rstn,
    output logic dom_rstn,
    output logic fail,
    output logic lock_lost,
    output logic run
);
    localparam int MAX_AB  = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_WAIT, S_STABLE, S_RUN, S_FAIL
    } state_t;

    state_t           st, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RTY_W-1:0] rty, rty_nxt;
    logic [1:0]       lock_sync;
    logic             lock_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_sync <= '0;
        else     lock_sync <= {lock_sync[0], lock_a};
    end
    assign lock_s = lock_sync[1];

    always_comb begin
        nxt     = st;
        rty_nxt = rty;
        case (st)
            S_IDLE:   if (pred_ok) nxt = S_RESET;
            S_RESET:  if (cnt == HOLD_LAST) nxt = S_WAIT;
            S_WAIT: begin
                // lock seen in the timeout cycle still counts as a success
                if (lock_s) begin
                    nxt = S_STABLE;
                end else if (cnt == TMO_LAST) begin
                    if (rty < RTY_MAX) begin
                        rty_nxt = rty + RTY_W'(1);
                        nxt     = S_RESET;
                    end else begin
                        nxt = S_FAIL;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s)              nxt = S_WAIT;
                else if (cnt == STB_LAST) nxt = S_RUN;
            end
            S_RUN: begin
                if (!lock_s) begin
                    nxt     = S_RESET;
                    rty_nxt = '0;
                end
            end
            S_FAIL:   nxt = S_FAIL;
            default:  nxt = S_IDLE;
        endcase
        if (!en) begin
            nxt     = S_IDLE;
            rty_nxt = '0;
        end
    end

    // counter restarts on every state entry and saturates otherwise
    always_comb begin
        if (nxt != st)      cnt_nxt = '0;
        else if (&cnt)      cnt_nxt = cnt;
        else                cnt_nxt = cnt + CNT_W'(1);
    end

    // outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            cnt       <= '0;
            rty       <= '0;
            pll_rstn  <= 1'b0;
            dom_rstn  <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            st        <= nxt;
            cnt       <= cnt_nxt;
            rty       <= rty_nxt;
            pll_rstn  <= (nxt == S_WAIT) || (nxt == S_STABLE) || (nxt == S_RUN);
            dom_rstn  <= (nxt == S_RUN);
            fail      <= (nxt == S_FAIL);
            lock_lost <= (st == S_RUN) && (nxt == S_RESET);
        end
    end

    assign run = (st == S_RUN);
endmodule

module pll_bringup_seq #(
    parameter int N_PLL        = 3,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRY    = 2,
    parameter int SEQ_MODE     = 0
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic [N_PLL-1:0] pll_en_i,
    input  logic [N_PLL-1:0] pll_lock_i,
    output logic [N_PLL-1:0] pll_rstn_o,
    output logic [N_PLL-1:0] domain_rstn_o,
    output logic [N_PLL-1:0] fail_o,
    output logic [N_PLL-1:0] lock_lost_o,
    output logic             all_ready_o
);
    logic [N_PLL-1:0] pred_ok;
    logic [N_PLL-1:0] run;

    // ordered start-up: a channel may leave IDLE once its predecessor runs or is disabled
    assign pred_ok[0] = 1'b1;
    for (genvar k = 1; k < N_PLL; k++) begin : g_pred
        assign pred_ok[k] = (SEQ_MODE == 0) || !pll_en_i[k-1] || run[k-1];
    end

    pll_bringup_ch #(
        .RST_HOLD     (RST_HOLD),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .MAX_RETRY    (MAX_RETRY)
    ) u_ch [N_PLL-1:0] (
        .clk       (sys_clk_i),
        .rst       (sys_rst_i),
        .en        (pll_en_i),
        .lock_a    (pll_lock_i),
        .pred_ok   (pred_ok),
        .pll_rstn  (pll_rstn_o),
        .dom_rstn  (domain_rstn_o),
        .fail      (fail_o),
        .lock_lost (lock_lost_o),
        .run       (run)
    );

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) all_ready_o <= 1'b0;
        else           all_ready_o <= (|pll_en_i) && (&(run | ~pll_en_i));
    end
endmodule

// File: tb/tb_pll_bringup_seq.sv
// Bench for pll_bringup_seq: event scoreboard on output edges, a vector table for
// enable/lock patterns, and hand sequences for timeout, glitch, async reset and ordered start.

module tb_pll_bringup_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en, lock, s_en, s_lock;
    logic [2:0] prst, dom, fail, lost, s_prst, s_dom, s_fail, s_lost;
    logic       rdy, s_rdy;

    always #5 clk = ~clk;

    pll_bringup_seq #(.N_PLL(3), .SEQ_MODE(0)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .pll_en_i(en), .pll_lock_i(lock),
        .pll_rstn_o(prst), .domain_rstn_o(dom), .fail_o(fail), .lock_lost_o(lost),
        .all_ready_o(rdy));

    pll_bringup_seq #(.N_PLL(3), .SEQ_MODE(1)) dut_s (
        .sys_clk_i(clk), .sys_rst_i(rst), .pll_en_i(s_en), .pll_lock_i(s_lock),
        .pll_rstn_o(s_prst), .domain_rstn_o(s_dom), .fail_o(s_fail), .lock_lost_o(s_lost),
        .all_ready_o(s_rdy));

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: pll_rstn rise, 1: domain_rstn rise, 2: lock_lost pulse
    typedef struct { int kind; int ch; int cyc; } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [2:0] en, lock;
        int         wait_n;
        logic [2:0] prst, dom, fail;
        logic       rdy;
    } vec_t;
    vec_t tbl[7];

    logic       mon_en = 1'b1;
    logic [2:0] prev_prst = '0, prev_dom = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int ch, input int at);
        ev_t e;
        e.kind = kind; e.ch = ch; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic sb_hit(input int kind, input int ch);
        int idx = -1;
        for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].kind == kind && sb[i].ch == ch) idx = i;
        if (idx < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_k%0d_ch%0d: event at cycle %0d, nothing expected", kind, ch, cyc);
        end else begin
            chk($sformatf("sb_k%0d_ch%0d_cycle", kind, ch), cyc, sb[idx].cyc);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (prst[k] && !prev_prst[k]) sb_hit(0, k);
                if (dom[k] && !prev_dom[k])   sb_hit(1, k);
                if (lost[k])                  sb_hit(2, k);
            end
        end
        prev_prst = prst;
        prev_dom  = dom;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e, l, d, g, r, t, u;
        tbl[0] = '{3'b101, 3'b101,   2, 3'b101, 3'b101, 3'b000, 1'b1};
        tbl[1] = '{3'b001, 3'b101,   2, 3'b001, 3'b001, 3'b000, 1'b1};
        tbl[2] = '{3'b000, 3'b101,   2, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[3] = '{3'b100, 3'b100,   2, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[4] = '{3'b100, 3'b100,  20, 3'b100, 3'b000, 3'b000, 1'b0};
        tbl[5] = '{3'b100, 3'b100, 260, 3'b100, 3'b100, 3'b000, 1'b1};
        tbl[6] = '{3'b110, 3'b100,  30, 3'b110, 3'b100, 3'b000, 1'b0};

        rst = 1'b1; en = '0; lock = '0; s_en = '0; s_lock = '0;
        step(3);
        chk("rst_prst", prst, 0); chk("rst_dom", dom, 0); chk("rst_fail", fail, 0);
        chk("rst_lost", lost, 0); chk("rst_rdy", rdy, 0);
        rst = 1'b0;
        step(2);

        // parallel bring-up, locks arrive 100 cycles after PLL reset release
        en = 3'b111; e = cyc;
        for (int k = 0; k < 3; k++) push(0, k, e + 17);
        for (int i = 0; i < 40 && prst != 3'b111; i++) step(1);
        chk("t1_prst_up", prst, 3'b111);
        step(100);
        lock = 3'b111; l = cyc;
        for (int k = 0; k < 3; k++) push(1, k, l + 259);
        for (int i = 0; i < 400 && dom != 3'b111; i++) step(1);
        chk("t1_dom_up", dom, 3'b111);
        chk("t1_rdy_lag", rdy, 0);
        step(1);
        chk("t1_rdy", rdy, 1);

        // lock loss in RUN on channel 0
        lock[0] = 1'b0; d = cyc;
        push(2, 0, d + 3); push(0, 0, d + 19); push(1, 0, d + 276);
        step(2); chk("t3_dom_hold", dom, 3'b111);
        step(1); chk("t3_dom_drop", dom, 3'b110);
        step(1); chk("t3_rdy_drop", rdy, 0); chk("t3_others", dom, 3'b110);
        step(1); lock[0] = 1'b1;
        for (int i = 0; i < 400 && !rdy; i++) step(1);
        chk("t3_rdy_back", rdy, 1);

        // 3-cycle lock glitch while channel 0 is at STABLE count 200
        en[0] = 1'b0; lock[0] = 1'b0;
        step(2);
        en[0] = 1'b1; e = cyc; push(0, 0, e + 17);
        step(27);
        lock[0] = 1'b1; l = cyc;
        step(201);
        lock[0] = 1'b0; g = cyc; push(1, 0, g + 262);
        step(3); lock[0] = 1'b1;
        step(3);
        chk("t5_no_reset", prst, 3'b111); chk("t5_no_fail", fail, 0);
        for (int i = 0; i < 400 && !rdy; i++) step(1);
        chk("t5_rdy_back", rdy, 1);

        // channel 1 never locks: three attempts then FAIL
        en[1] = 1'b0; lock[1] = 1'b0;
        step(2);
        en[1] = 1'b1; e = cyc;
        push(0, 1, e + 17); push(0, 1, e + 4129); push(0, 1, e + 8241);
        step(12336);
        chk("t2_fail_early", fail, 0); chk("t2_rdy_wait", rdy, 0);
        step(1);
        chk("t2_fail", fail, 3'b010); chk("t2_rdy_fail", rdy, 0); chk("t2_prst_fail", prst, 3'b101);
        en[1] = 1'b0;
        step(1); chk("t2_fail_clr", fail, 0);
        step(1); chk("t2_rdy_dis", rdy, 1);

        // enable/lock pattern table
        mon_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            en = tbl[i].en; lock = tbl[i].lock;
            step(tbl[i].wait_n);
            chk($sformatf("tbl%0d_prst", i), prst, tbl[i].prst);
            chk($sformatf("tbl%0d_dom", i),  dom,  tbl[i].dom);
            chk($sformatf("tbl%0d_fail", i), fail, tbl[i].fail);
            chk($sformatf("tbl%0d_rdy", i),  rdy,  tbl[i].rdy);
        end
        mon_en = 1'b1;

        // asynchronous reset while channel 1 is in STABLE
        lock = 3'b110;
        step(100);
        #2 rst = 1'b1;
        #1;
        chk("t6_prst", prst, 0); chk("t6_dom", dom, 0); chk("t6_fail", fail, 0);
        chk("t6_lost", lost, 0); chk("t6_rdy", rdy, 0);
        step(2);
        rst = 1'b0; r = cyc;
        push(0, 1, r + 17); push(0, 2, r + 17); push(1, 1, r + 274); push(1, 2, r + 274);
        for (int i = 0; i < 400 && !rdy; i++) step(1);
        chk("t6_rdy_back", rdy, 1);
        chk("sb_empty", sb.size(), 0);

        // ordered start-up on the SEQ_MODE=1 instance
        s_en = 3'b111; s_lock = 3'b110;
        step(17);  chk("t4_ch0_only", s_prst, 3'b001);
        step(1000); s_lock = 3'b111; t = cyc;
        step(259); chk("t4_ch0_run", s_dom, 3'b001); chk("t4_ch1_held", s_prst, 3'b001);
        step(16);  chk("t4_ch1_rst", s_prst, 3'b001);
        step(1);   chk("t4_ch1_up", s_prst, 3'b011);
        step(273); chk("t4_ch2_rst", s_prst, 3'b011);
        step(1);   chk("t4_ch2_up", s_prst, 3'b111);
        step(260); chk("t4_rdy", s_rdy, 1);
        s_en = 3'b000;
        step(2);
        s_en = 3'b111; s_lock = 3'b110;
        step(50);  chk("t4b_ch0_wait", s_prst, 3'b001);
        s_en = 3'b110; u = cyc;
        step(16);  chk("t4b_ch1_rst", s_prst, 3'b000);
        step(1);   chk("t4b_ch1_up", s_prst, 3'b010);
        chk("t4b_t_ref", cyc - u, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
